// File: rtl/rom_arbiter_if.sv
// rtl/rom_arbiter_if.sv - requester and SRAM port bundle for the cart memory arbiter
interface rom_arbiter_if;
    logic        snes_req;
    logic        snes_we;
    logic [23:0] snes_addr;
    logic [7:0]  snes_wdata;
    logic        snes_wr_allow;
    logic [7:0]  snes_rdata;
    logic        snes_rdy;
    logic        snes_overrun;

    logic        mcu_req;
    logic        mcu_we;
    logic [23:0] mcu_addr;
    logic [7:0]  mcu_wdata;
    logic [7:0]  mcu_rdata;
    logic        mcu_ack;

    logic        dma_req;
    logic        dma_we;
    logic [23:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic [7:0]  dma_rdata;
    logic        dma_ack;

    logic [23:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_drive;
    logic        mem_oe_n;
    logic        mem_we_n;
    logic        busy;

    modport slave (
        input  snes_req, snes_we, snes_addr, snes_wdata, snes_wr_allow,
        output snes_rdata, snes_rdy, snes_overrun,
        input  mcu_req, mcu_we, mcu_addr, mcu_wdata,
        output mcu_rdata, mcu_ack,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_addr, mem_dout, mem_drive, mem_oe_n, mem_we_n, busy,
        input  mem_din
    );

    modport master (
        output snes_req, snes_we, snes_addr, snes_wdata, snes_wr_allow,
        input  snes_rdata, snes_rdy, snes_overrun,
        output mcu_req, mcu_we, mcu_addr, mcu_wdata,
        input  mcu_rdata, mcu_ack,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_addr, mem_dout, mem_drive, mem_oe_n, mem_we_n, busy,
        output mem_din
    );
endinterface

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - cart SRAM port sequencer: SNES absolute priority, MCU/DMA round-robin
module rom_arbiter #(
    parameter int ACC_CYCLES = 3,
    parameter int REC_CYCLES = 1
) (
    input logic          clk,
    input logic          rst,
    rom_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SNES_ACC, MCU_ACC, DMA_ACC, RECOVER} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        grant_snes, grant_mcu, grant_dma, done;

    logic        snes_pend;
    logic        rr_dma;
    logic        cur_rd;
    logic        s_we, s_allow;
    logic [23:0] s_addr;
    logic [7:0]  s_wdata;

    logic        g_we, g_allow;
    logic [23:0] g_addr;
    logic [7:0]  g_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        grant_snes = 1'b0;
        grant_mcu  = 1'b0;
        grant_dma  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (snes_pend || bus.snes_req) begin
                    state_n    = SNES_ACC;
                    cnt_n      = 4'(ACC_CYCLES - 1);
                    grant_snes = 1'b1;
                end else if (bus.mcu_req && (!rr_dma || !bus.dma_req)) begin
                    state_n   = MCU_ACC;
                    cnt_n     = 4'(ACC_CYCLES - 1);
                    grant_mcu = 1'b1;
                end else if (bus.dma_req) begin
                    state_n   = DMA_ACC;
                    cnt_n     = 4'(ACC_CYCLES - 1);
                    grant_dma = 1'b1;
                end
            end
            SNES_ACC, MCU_ACC, DMA_ACC: begin
                if (cnt == 4'd0) begin
                    state_n = RECOVER;
                    cnt_n   = 4'(REC_CYCLES - 1);
                    done    = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RECOVER: begin
                if (cnt == 4'd0) state_n = IDLE;
                else             cnt_n   = cnt - 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // A fresh SNES_REQ in IDLE is granted straight from the bus, bypassing the capture latch
    always_comb begin
        g_we    = bus.dma_we;
        g_allow = 1'b1;
        g_addr  = bus.dma_addr;
        g_wdata = bus.dma_wdata;
        if (grant_snes) begin
            if (snes_pend) begin
                g_we = s_we; g_allow = s_allow; g_addr = s_addr; g_wdata = s_wdata;
            end else begin
                g_we    = bus.snes_we;
                g_allow = bus.snes_wr_allow;
                g_addr  = bus.snes_addr;
                g_wdata = bus.snes_wdata;
            end
        end else if (grant_mcu) begin
            g_we = bus.mcu_we; g_addr = bus.mcu_addr; g_wdata = bus.mcu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_oe_n     <= 1'b1;
            bus.mem_we_n     <= 1'b1;
            bus.mem_drive    <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_dout     <= '0;
            bus.snes_rdy     <= 1'b0;
            bus.mcu_ack      <= 1'b0;
            bus.dma_ack      <= 1'b0;
            bus.snes_rdata   <= '0;
            bus.mcu_rdata    <= '0;
            bus.dma_rdata    <= '0;
            bus.snes_overrun <= 1'b0;
            snes_pend        <= 1'b0;
            rr_dma           <= 1'b0;
            cur_rd           <= 1'b0;
            s_we             <= 1'b0;
            s_allow          <= 1'b0;
            s_addr           <= '0;
            s_wdata          <= '0;
        end else begin
            bus.snes_rdy <= 1'b0;
            bus.mcu_ack  <= 1'b0;
            bus.dma_ack  <= 1'b0;

            if (bus.snes_req) begin
                if (snes_pend) begin
                    bus.snes_overrun <= 1'b1;
                end else begin
                    snes_pend <= 1'b1;
                    s_we      <= bus.snes_we;
                    s_allow   <= bus.snes_wr_allow;
                    s_addr    <= bus.snes_addr;
                    s_wdata   <= bus.snes_wdata;
                end
            end

            if (grant_snes || grant_mcu || grant_dma) begin
                bus.mem_addr  <= g_addr;
                bus.mem_dout  <= g_wdata;
                bus.mem_oe_n  <= g_we;
                bus.mem_we_n  <= !(g_we && g_allow);
                bus.mem_drive <= g_we && g_allow;
                cur_rd        <= !g_we;
            end
            if (grant_mcu) rr_dma <= 1'b1;
            if (grant_dma) rr_dma <= 1'b0;

            if (done) begin
                bus.mem_oe_n  <= 1'b1;
                bus.mem_we_n  <= 1'b1;
                bus.mem_drive <= 1'b0;
                if (state == SNES_ACC) begin
                    bus.snes_rdy <= 1'b1;
                    snes_pend    <= 1'b0;
                    if (cur_rd) bus.snes_rdata <= bus.mem_din;
                end
                if (state == MCU_ACC) begin
                    bus.mcu_ack <= 1'b1;
                    if (cur_rd) bus.mcu_rdata <= bus.mem_din;
                end
                if (state == DMA_ACC) begin
                    bus.dma_ack <= 1'b1;
                    if (cur_rd) bus.dma_rdata <= bus.mem_din;
                end
            end
        end
    end

    assign bus.busy = (state != IDLE);
endmodule
